outbus_uart_tx: RTL

Output-bus UART transmitter peripheral. Sits directly downstream of the OUTRIR/OUT instruction stage and consumes its registered `outbus_addr`/`outbus_data`/`outbus_we` strobe. Decodes a data and a control register at a base address, buffers written bytes in a small FIFO, and serializes them as 8N1 frames (optional parity) on `uart_tx`.

---
 rtl/outbus_uart_pkg.sv | 21 ++
 rtl/outbus_fifo.sv | 69 ++++++
 rtl/outbus_uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/outbus_uart_pkg.sv
// rtl/outbus_uart_pkg.sv - shared FSM states, control bit positions and helpers for outbus_uart_tx
package outbus_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int         CTRL_CLR_OVF = 0;
    localparam int         CTRL_FLUSH   = 1;
    localparam logic [7:0] CTRL_OFFSET  = 8'd1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/outbus_fifo.sv
// rtl/outbus_fifo.sv - synchronous byte FIFO with flush, used as the UART transmit buffer
module outbus_fifo
    import outbus_uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // Occupancy never exceeds DEPTH, so the count MSB alone marks full.
    assign full     = r_count[FIFO_AW];
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    // Flush wins over pop; a pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && !flush && (!full || w_do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/outbus_uart_tx.sv
// rtl/outbus_uart_tx.sv - output-bus UART transmitter, 8N1 or 8E1 when OUTBUS_UART_PARITY_EN is defined
module outbus_uart_tx
    import outbus_uart_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'h10,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter int          FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] outbus_addr,
    input  logic [7:0] outbus_data,
    input  logic       outbus_we,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam logic [7:0]  CTRL_ADDR = BASE_ADDR + CTRL_OFFSET;
    localparam logic [15:0] BAUD_LAST = CLKS_PER_BIT - 16'd1;

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_overflow;

    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_clr_ovf;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;
    logic        w_baud_last;
    logic [7:0]  w_head;

    assign w_data_wr   = outbus_we && (outbus_addr == BASE_ADDR);
    assign w_ctrl_wr   = outbus_we && (outbus_addr == CTRL_ADDR);
    assign w_flush     = w_ctrl_wr && outbus_data[CTRL_FLUSH];
    assign w_clr_ovf   = w_ctrl_wr && outbus_data[CTRL_CLR_OVF];
    assign w_baud_last = (r_baud == BAUD_LAST);
    // A write into a full FIFO is only lost if nothing is popped in the same cycle.
    assign w_drop      = w_data_wr && w_full && !w_pop;

    outbus_fifo #(
        .WIDTH   (8),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_data_wr),
        .push_data (outbus_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .flush     (w_flush),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next-state logic; every non-idle state ends on the last baud tick.
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !w_flush) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    // Wraps 7 -> 0, so the counter is already clear when DATA ends.
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef OUTBUS_UART_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef OUTBUS_UART_PARITY_EN
            ST_PARITY: begin
                if (w_baud_last) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_last) begin
                    // Chain straight into the next START so frames are gapless.
                    if (!w_empty && !w_flush) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so the flop output is valid on entry.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef OUTBUS_UART_PARITY_EN
            ST_PARITY: w_tx_next = even_parity(w_shift_next);
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    // State, baud/bit counters, shift register and registered serial line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= ((r_state == ST_IDLE) || w_baud_last) ? 16'd0 : (r_baud + 16'd1);
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    // Sticky overflow flag, cleared only through the control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign uart_tx    = r_tx;
    assign tx_busy    = (r_state != ST_IDLE) || !w_empty;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign overflow   = r_overflow;

endmodule
